timer_irq_responder: RTL and testbench
======================================

Name: timer_irq_responder

Overview:
Memory-mapped timer peripheral that answers the CPU's MEM-stage data accesses (MemRead/MemWrite/Address/Write_data/Read_data). It counts prescaled clock ticks, reloads on overflow, and raises a level interrupt for the CPU's Interrupt input (currently tied to 0 at the top). It sits beside the data memory. The top-level address decode steers reads using Hit.

Parameters:
BASE_ADDR, 32'h4000_0000, byte address of register block (16-byte aligned)
PRESCALE, 1, clk cycles per timer tick (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  CPU load strobe, same cycle as Address
MemWrite  input  1  CPU store strobe, same cycle as Address/Write_data
Address  input  32  byte address from EX/MEM ALU result
Write_data  input  32  store data
Read_data  output  32  load data, combinational
Hit  output  1  Address within BASE_ADDR..BASE_ADDR+0xF
Interrupt  output  1  level interrupt request to CPU

Behaviour:
- Register map (offset, word aligned; Address[1:0] ignored):
  - 0x0 TH: reload value, R/W.
  - 0x4 TL: counter, R/W.
  - 0x8 TCON: bit0 EN, bit1 IE, bit2 IS (status); other bits read 0.
  - 0xC SYSTICK: free-running clk cycle count, read-only, writes ignored.
- reset low (async): TH=TL=TCON=SYSTICK=0, prescaler=0, Interrupt=0. Read_data stays combinational.
- Read_data = selected register when MemRead&&Hit, else 32'h0. There is no read side effect, so the register value is visible in the same cycle.
- Writes take effect at the clk edge where MemWrite&&Hit.
- Prescaler counts 0..PRESCALE-1 only while EN=1, and is held at 0 when EN=0. tick is asserted in the cycle the prescaler equals PRESCALE-1. With PRESCALE=1, tick=EN every cycle.
- On tick: if TL==32'hFFFF_FFFF, then TL<=TH and IS<=IS|IE (overflow); else TL<=TL+1 (mod 2^32).
- SYSTICK increments every cycle and wraps at 2^32.
- Interrupt = IS & IE, registered, so it is visible in the cycle after IS is set.
- TCON writes load EN/IE from Write_data[1:0]. Writing IS=0 clears it; writing IS=1 is ignored.
- Simultaneous events:
  - CPU write to TL on a tick cycle: the write wins and there is no increment.
  - Overflow set and software clear of IS on the same edge: the set wins.
  - Write to TH on an overflow edge: the reload uses the old TH.
- EN cleared mid-count: TL freezes and the prescaler resets.
- reset asserted mid-operation: everything returns to reset values immediately.

Optional Feature:
TIMER_ONESHOT_EN.
- Defined: TCON bit3 OS is R/W. On an overflow edge with OS=1, EN<=0 on that edge while the reload and IS update proceed normally.
- Undefined: bit3 reads 0, writes to it are ignored, and the timer is always periodic.

Decomposition:
- Package timer_pkg: register offsets (TH_OFF, TL_OFF, TCON_OFF, SYSTICK_OFF), TCON bit indices (EN_BIT, IE_BIT, IS_BIT, OS_BIT), and the TCON width.
- Sub-module tick_prescaler(clk, reset, en, tick), parameterised by PRESCALE.

Test Plan:
1. Reset check: hold reset low, then release. Reads of 0x4000_0000..0x4000_000C return 0, except SYSTICK which counts up from 0 starting after release. Interrupt=0.
2. Overflow interrupt, PRESCALE=1: write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, then TCON=0x3. TL is 0xFFFF_FFFF after tick 1 and 0xFFFF_FFFD after tick 2, IS=1, and Interrupt=1 one cycle later. A read of TCON returns 0x7.
3. Clear and collision: write TCON=0x3 to clear IS and Interrupt falls. Repeat with the clear landing exactly on an overflow edge: IS remains 1.
4. Prescaler, PRESCALE=4: TL=0, EN=1. TL reads 1 after 4 cycles and 3 after 12 cycles. Clear EN: TL frozen at its value.
5. Decode boundaries: Address 0x4000_0010 or 0x3FFF_FFFC gives Hit=0, Read_data=0, and writes have no effect. A write to SYSTICK is ignored and the count continues.
6. TIMER_ONESHOT_EN build: TCON=0xB with TL=0xFFFF_FFFF gives one overflow, after which TCON reads 0xE (EN cleared) and TL holds the TH value.

Source files
------------

// File: rtl/timer_irq_responder_pkg.sv
// Purpose: shared constants for the timer_irq_responder peripheral.
//   Register byte offsets inside the 16-byte block, TCON bit positions,
//   TCON width and bus widths.
package timer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Byte offsets of the four word registers
    localparam logic [3:0] TH_OFF      = 4'h0;
    localparam logic [3:0] TL_OFF      = 4'h4;
    localparam logic [3:0] TCON_OFF    = 4'h8;
    localparam logic [3:0] SYSTICK_OFF = 4'hC;

    // TCON bit positions
    localparam int unsigned EN_BIT = 0;
    localparam int unsigned IE_BIT = 1;
    localparam int unsigned IS_BIT = 2;
    localparam int unsigned OS_BIT = 3;
    localparam int unsigned TCON_W = 4;

endpackage

// File: rtl/timer_irq_responder_if.sv
// Purpose: CPU MEM-stage data access bus as seen by the timer peripheral.
//   master : CPU side   (drives MemRead, MemWrite, Address, Write_data)
//   slave  : peripheral (drives Read_data, Hit)
interface timer_irq_responder_if;
    import timer_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Write_data;
    logic [DATA_W-1:0] Read_data;
    logic              Hit;

    modport master (
        output MemRead, MemWrite, Address, Write_data,
        input  Read_data, Hit
    );

    modport slave (
        input  MemRead, MemWrite, Address, Write_data,
        output Read_data, Hit
    );

endinterface

// File: rtl/timer_irq_responder_tick.sv
// Purpose: tick_prescaler - divides clk by PRESCALE while enabled.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable; the counter is held at 0 while low
//   tick  : high in the cycle the counter equals PRESCALE-1 (combinational)
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrap at LAST, clear whenever disabled
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/timer_irq_responder.sv
// Purpose: memory-mapped timer beside the data memory. Counts prescaled
//   ticks in TL, reloads from TH on overflow and raises a level interrupt.
//   Build option: define TIMER_ONESHOT_EN to add TCON.OS (one-shot mode).
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   bus       : CPU data access (slave modport); Read_data/Hit combinational
//   Interrupt : registered IS & IE
module timer_irq_responder
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_irq_responder_if.slave  bus,
    output logic                  Interrupt
);

    localparam int unsigned W = DATA_W;

    logic [W-1:0]      th_q, th_d, tl_q, tl_d, systick_q;
    logic              en_q, en_d, ie_q, ie_d, is_q, is_d, os_q;
    logic              irq_q;
    logic              hit, wr, tick, overflow;
    logic [3:0]        off;
    logic [TCON_W-1:0] tcon;
    logic              unused_bits;

`ifdef TIMER_ONESHOT_EN
    logic              os_d;
`else
    assign os_q = 1'b0;
`endif

    // Word-aligned decode: Address[1:0] ignored
    assign off = {bus.Address[3:2], 2'b00};
    assign hit = (bus.Address[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
    assign wr  = bus.MemWrite && hit;

    assign unused_bits = ^{bus.Address[1:0], bus.Write_data[W-1:TCON_W],
                           bus.Write_data[OS_BIT]};

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .tick  (tick)
    );

    assign overflow = tick && (tl_q == '1);

    // Next state: timer update first, CPU write overrides it, overflow status last
    always_comb begin
        th_d = th_q;
        tl_d = tl_q;
        en_d = en_q;
        ie_d = ie_q;
        is_d = is_q;
`ifdef TIMER_ONESHOT_EN
        os_d = os_q;
`endif
        if (tick) begin
            tl_d = overflow ? th_q : tl_q + W'(1);
        end
        if (wr) begin
            case (off)
                TH_OFF: th_d = bus.Write_data;
                TL_OFF: tl_d = bus.Write_data;
                TCON_OFF: begin
                    en_d = bus.Write_data[EN_BIT];
                    ie_d = bus.Write_data[IE_BIT];
                    if (!bus.Write_data[IS_BIT]) begin
                        is_d = 1'b0;
                    end
`ifdef TIMER_ONESHOT_EN
                    os_d = bus.Write_data[OS_BIT];
`endif
                end
                default: ;
            endcase
        end
        // Hardware set beats a same-edge software clear
        if (overflow && ie_q) begin
            is_d = 1'b1;
        end
`ifdef TIMER_ONESHOT_EN
        if (overflow && os_q) begin
            en_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            is_q      <= 1'b0;
            systick_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            is_q      <= is_d;
            systick_q <= systick_q + W'(1);
            irq_q     <= is_q && ie_q;
        end
    end

`ifdef TIMER_ONESHOT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_q <= 1'b0;
        end else begin
            os_q <= os_d;
        end
    end
`endif

    // TCON read image; OS reads 0 when the one-shot option is absent
    always_comb begin
        tcon         = '0;
        tcon[EN_BIT] = en_q;
        tcon[IE_BIT] = ie_q;
        tcon[IS_BIT] = is_q;
        tcon[OS_BIT] = os_q;
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        bus.Read_data = '0;
        if (bus.MemRead && hit) begin
            case (off)
                TH_OFF:      bus.Read_data = th_q;
                TL_OFF:      bus.Read_data = tl_q;
                TCON_OFF:    bus.Read_data = W'(tcon);
                SYSTICK_OFF: bus.Read_data = systick_q;
                default:     bus.Read_data = '0;
            endcase
        end
    end

    assign bus.Hit   = hit;
    assign Interrupt = irq_q;

endmodule

// File: tb/tb_timer_irq_responder.sv
// Bench for timer_irq_responder: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_timer_irq_responder;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_000C;

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    logic        clk;
    logic        reset;
    logic        irq1, irq4;
    int          checks;
    int          errors;
    int unsigned cycles;
    rd_exp_t     sb[$];

    timer_irq_responder_if bus1 ();
    timer_irq_responder_if bus4 ();

    timer_irq_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .Interrupt (irq1)
    );

    timer_irq_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4),
        .Interrupt (irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cycles <= 0;
        else        cycles <= cycles + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One write: drive now, effect at the next posedge, return at the following negedge
    task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin
            bus1.Address = a; bus1.Write_data = d; bus1.MemWrite = 1'b1;
        end else begin
            bus4.Address = a; bus4.Write_data = d; bus4.MemWrite = 1'b1;
        end
        @(negedge clk);
        bus1.MemWrite = 1'b0;
        bus4.MemWrite = 1'b0;
    endtask

    task automatic rd(input int sel, input logic [31:0] a, input logic re,
                      output logic [31:0] d, output logic h);
        if (sel == 1) begin
            bus1.Address = a; bus1.MemRead = re;
        end else begin
            bus4.Address = a; bus4.MemRead = re;
        end
        #1;
        d = (sel == 1) ? bus1.Read_data : bus4.Read_data;
        h = (sel == 1) ? bus1.Hit : bus4.Hit;
        bus1.MemRead = 1'b0;
        bus4.MemRead = 1'b0;
    endtask

    task automatic test_reset();
        rd_exp_t e; logic [31:0] d; logic h;
        reset = 1'b0;
        step(2);
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("FAIL rst_irq1: got %b exp 0", irq1); end
        checks++;
        if (irq4 !== 1'b0) begin errors++; $display("FAIL rst_irq4: got %b exp 0", irq4); end
        sb.push_back('{1, A_TH, 32'h0, "rst_th"});
        sb.push_back('{1, A_TL, 32'h0, "rst_tl"});
        sb.push_back('{1, A_TCON, 32'h0, "rst_tcon"});
        sb.push_back('{1, A_SYS, 32'h0, "rst_systick"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        reset = 1'b1;
        step(3);
        sb.push_back('{4, A_SYS, 32'(cycles), "post_rst_systick"});
        sb.push_back('{4, A_TH, 32'h0, "post_rst_th"});
        sb.push_back('{4, A_TL, 32'h0, "post_rst_tl"});
        sb.push_back('{4, A_TCON, 32'h0, "post_rst_tcon"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("FAIL post_rst_irq: got %b exp 0", irq1); end
    endtask

    task automatic test_overflow();
        rd_exp_t e; logic [31:0] d; logic h;
        step(1);
        wr(1, A_TH, 32'hFFFF_FFFD);
        wr(1, A_TL, 32'hFFFF_FFFE);
        wr(1, A_TCON, 32'h3);
        sb.push_back('{1, A_TL, 32'hFFFF_FFFE, "ovf_tl_start"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        sb.push_back('{1, A_TL, 32'hFFFF_FFFF, "ovf_tl_tick1"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        sb.push_back('{1, A_TL, 32'hFFFF_FFFD, "ovf_tl_reload"});
        sb.push_back('{1, A_TCON, 32'h7, "ovf_tcon_is"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("FAIL ovf_irq_early: got %b exp 0", irq1); end
        step(1);
        checks++;
        if (irq1 !== 1'b1) begin errors++; $display("FAIL ovf_irq_rise: got %b exp 1", irq1); end
        sb.push_back('{1, A_TL, 32'hFFFF_FFFE, "ovf_tl_after"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
    endtask

    // Continues directly from test_overflow (TL=FFFF_FFFE, EN=IE=IS=1)
    task automatic test_clear_collision();
        rd_exp_t e; logic [31:0] d; logic h;
        wr(1, A_TCON, 32'h2);
        sb.push_back('{1, A_TCON, 32'h2, "clr_tcon"});
        sb.push_back('{1, A_TL, 32'hFFFF_FFFF, "clr_tl"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        checks++;
        if (irq1 !== 1'b1) begin errors++; $display("FAIL clr_irq_lag: got %b exp 1", irq1); end
        step(1);
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("FAIL clr_irq_fall: got %b exp 0", irq1); end
        wr(1, A_TCON, 32'h3);
        wr(1, A_TCON, 32'h3);
        sb.push_back('{1, A_TCON, 32'h7, "coll_is_set_wins"});
        sb.push_back('{1, A_TL, 32'hFFFF_FFFD, "coll_tl_reload"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        checks++;
        if (irq1 !== 1'b1) begin errors++; $display("FAIL coll_irq: got %b exp 1", irq1); end
        wr(1, A_TCON, 32'h0);
    endtask

    task automatic test_prescaler();
        rd_exp_t e; logic [31:0] d; logic h;
        logic [31:0] exp_tl[5] = '{32'd0, 32'd1, 32'd3, 32'd3, 32'd3};
        int          gap[5]    = '{3, 1, 8, 0, 0};
        string       nm[5]     = '{"pre_tl_3cyc", "pre_tl_4cyc", "pre_tl_12cyc",
                                   "pre_tl_frozen", "pre_tl_frozen_late"};
        step(1);
        wr(4, A_TCON, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                step(1);
                wr(4, A_TCON, 32'h0);
            end
            if (i == 4) step(6);
            step(gap[i]);
            sb.push_back('{4, A_TL, exp_tl[i], nm[i]});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
                if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
            end
        end
        // Re-enable: prescaler must restart from 0, so the next tick is 4 cycles out
        wr(4, A_TCON, 32'h1);
        step(3);
        sb.push_back('{4, A_TL, 32'd3, "pre_restart_3cyc"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        sb.push_back('{4, A_TL, 32'd4, "pre_restart_4cyc"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        wr(4, A_TCON, 32'h0);
    endtask

    // dut1 state here: TH=FFFF_FFFD, TL=FFFF_FFFF, TCON=0
    task automatic test_decode();
        rd_exp_t e; logic [31:0] d; logic h;
        logic [31:0] miss[3] = '{32'h4000_0010, 32'h3FFF_FFFC, 32'h3FFF_FFF0};
        step(1);
        for (int i = 0; i < 3; i++) begin
            rd(1, miss[i], 1'b1, d, h);
            checks++;
            if (h !== 1'b0) begin errors++; $display("FAIL dec_hit_%0d: got %b exp 0", i, h); end
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL dec_data_%0d: got %h exp 0", i, d); end
        end
        rd(1, 32'h4000_000F, 1'b0, d, h);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL dec_hit_top: got %b exp 1", h); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL dec_noread: got %h exp 0", d); end
        wr(1, 32'h4000_0010, 32'h1111_1111);
        wr(1, 32'h3FFF_FFF0, 32'h2222_2222);
        wr(1, 32'h4000_0014, 32'h0);
        wr(1, A_SYS, 32'h0);
        sb.push_back('{1, 32'h4000_0003, 32'hFFFF_FFFD, "dec_th_untouched"});
        sb.push_back('{1, A_TL, 32'hFFFF_FFFF, "dec_tl_untouched"});
        sb.push_back('{1, A_SYS, 32'(cycles), "dec_systick_ro"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
    endtask

    task automatic test_oneshot();
        rd_exp_t e; logic [31:0] d; logic h;
        step(1);
        wr(1, A_TH, 32'h0000_0055);
        wr(1, A_TL, 32'hFFFF_FFFF);
        wr(1, A_TCON, 32'hB);
        step(1);
`ifdef TIMER_ONESHOT_EN
        sb.push_back('{1, A_TCON, 32'hE, "os_tcon_after"});
        sb.push_back('{1, A_TL, 32'h55, "os_tl_reload"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(3);
        sb.push_back('{1, A_TL, 32'h55, "os_tl_stopped"});
        sb.push_back('{1, A_TCON, 32'hE, "os_tcon_held"});
`else
        sb.push_back('{1, A_TCON, 32'h7, "per_tcon_after"});
        sb.push_back('{1, A_TL, 32'h55, "per_tl_reload"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(3);
        sb.push_back('{1, A_TL, 32'h58, "per_tl_running"});
        sb.push_back('{1, A_TCON, 32'h7, "per_tcon_os_zero"});
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        checks++;
        if (irq1 !== 1'b1) begin errors++; $display("FAIL os_irq: got %b exp 1", irq1); end
    endtask

    task automatic test_mid_reset();
        rd_exp_t e; logic [31:0] d; logic h;
        step(1);
        wr(4, A_TCON, 32'h3);
        step(5);
        reset = 1'b0;
        #1;
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b exp 0", irq1); end
        sb.push_back('{4, A_TCON, 32'h0, "mid_rst_tcon"});
        sb.push_back('{1, A_TH, 32'h0, "mid_rst_th"});
        sb.push_back('{4, A_SYS, 32'h0, "mid_rst_systick"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.sel, e.addr, 1'b1, d, h); checks++;
            if (d !== e.exp) begin errors++; $display("FAIL %s: got %h exp %h", e.name, d, e.exp); end
        end
        step(1);
        reset = 1'b1;
        step(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.Address = '0; bus1.Write_data = '0;
        bus4.MemRead = 1'b0; bus4.MemWrite = 1'b0; bus4.Address = '0; bus4.Write_data = '0;
        test_reset();
        test_overflow();
        test_clear_collision();
        test_prescaler();
        test_decode();
        test_oneshot();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
